// File: rtl/gnn_buffer_pkg.sv
// Shared feature-buffer constants and the save-reader state encoding.
package gnn_buffer_pkg;

    localparam int BUFFER_ADDR_WIDTH   = 11;
    localparam int BUFFER_DATA_WIDTH   = 512;
    localparam int BUFFER_READ_LATENCY = 4;
    localparam int SAVE_LEN_WIDTH      = 12;
    localparam int SAVE_FIFO_DEPTH     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } save_reader_state_t;

endpackage

// File: rtl/buffer_save_reader_if.sv
// Command, buffer save-port and output-stream signals of the save reader.
// Perf counter outputs exist only when SAVE_READER_PERF_EN is defined.
interface buffer_save_reader_if
    import gnn_buffer_pkg::*;
#(
    parameter int ADDR_W = BUFFER_ADDR_WIDTH,
    parameter int DATA_W = BUFFER_DATA_WIDTH,
    parameter int LEN_W  = SAVE_LEN_WIDTH
);
    // Every stream moves a beat on a cycle where valid and ready are both high;
    // valid never waits for ready and payload is held while valid & !ready.
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_base_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              port_free;
    logic              save_read_addr_valid;
    logic [ADDR_W-1:0] save_read_addr;
    logic              save_read_data_valid;
    logic [DATA_W-1:0] save_read_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              done;
`ifdef SAVE_READER_PERF_EN
    logic [31:0]       perf_port_stall;
    logic [31:0]       perf_out_stall;
`endif

    modport master (
        input  cmd_valid, cmd_base_addr, cmd_len, port_free,
        input  save_read_data_valid, save_read_data, out_ready,
        output cmd_ready, save_read_addr_valid, save_read_addr,
        output out_valid, out_data, out_last, done
`ifdef SAVE_READER_PERF_EN
        , output perf_port_stall, perf_out_stall
`endif
    );

    modport slave (
        output cmd_valid, cmd_base_addr, cmd_len, port_free,
        output save_read_data_valid, save_read_data, out_ready,
        input  cmd_ready, save_read_addr_valid, save_read_addr,
        input  out_valid, out_data, out_last, done
`ifdef SAVE_READER_PERF_EN
        , input perf_port_stall, perf_out_stall
`endif
    );

endinterface

// File: rtl/save_data_fifo.sv
// First-word-fall-through FIFO holding returned buffer lines for the save stream.
module save_data_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             full, do_pop;

    assign full    = count_q == CW'(DEPTH);
    assign empty_o = count_q == '0;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push_i && !do_pop) count_q <= count_q + CW'(1);
            else if (!push_i && do_pop) count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    // Credit accounting upstream guarantees room; a push into a full FIFO
    // without a same-cycle pop means that accounting is broken.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && full && !do_pop));

endmodule

// File: rtl/buffer_save_reader.sv
// Save-path read engine: issues buffer reads when the port is free, absorbs the
// read latency with credits + FWFT FIFO. Optional perf counters: SAVE_READER_PERF_EN.
module buffer_save_reader
    import gnn_buffer_pkg::*;
#(
    parameter int BUFFER_ADDR_WIDTH = gnn_buffer_pkg::BUFFER_ADDR_WIDTH,
    parameter int BUFFER_DATA_WIDTH = gnn_buffer_pkg::BUFFER_DATA_WIDTH,
    parameter int LEN_WIDTH         = SAVE_LEN_WIDTH,
    parameter int READ_LATENCY      = BUFFER_READ_LATENCY,
    parameter int FIFO_DEPTH        = SAVE_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    buffer_save_reader_if.master  bus,
    output save_reader_state_t    dbg_state_o
);
    localparam int CREDIT_W = $clog2(FIFO_DEPTH + 1);
    localparam int DROP_W   = $clog2(READ_LATENCY + 1);

    save_reader_state_t           state_q;
    logic [BUFFER_ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]         len_q, issue_cnt_q, ret_cnt_q;
    logic [CREDIT_W-1:0]          credits_q;
    logic [DROP_W-1:0]            drop_cnt_q;
    logic                         done_q;

    logic                         accept, issue, push, pop, push_last;
    logic                         fifo_empty, head_last;
    logic [BUFFER_DATA_WIDTH-1:0] head_data;

    assign accept    = bus.cmd_valid && state_q == IDLE;
    assign issue     = state_q == ISSUE && bus.port_free && credits_q < CREDIT_W'(FIFO_DEPTH);
    assign push      = bus.save_read_data_valid && drop_cnt_q == '0;
    assign pop       = !fifo_empty && bus.out_ready;
    assign push_last = ret_cnt_q == len_q - LEN_WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            issue_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        issue_cnt_q <= '0;
                        if (bus.cmd_len != '0) begin
                            addr_q  <= bus.cmd_base_addr;
                            len_q   <= bus.cmd_len;
                            state_q <= ISSUE;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        addr_q      <= addr_q + BUFFER_ADDR_WIDTH'(1);
                        issue_cnt_q <= issue_cnt_q + LEN_WIDTH'(1);
                        if (issue_cnt_q == len_q - LEN_WIDTH'(1)) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && head_last) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Credits cover reads in flight plus lines already queued, so a pop is
    // what frees a slot, not the data return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits_q  <= '0;
            ret_cnt_q  <= '0;
            drop_cnt_q <= DROP_W'(READ_LATENCY);
        end else begin
            if (issue && !pop) credits_q <= credits_q + CREDIT_W'(1);
            else if (!issue && pop) credits_q <= credits_q - CREDIT_W'(1);
            if (accept) ret_cnt_q <= '0;
            else if (push) ret_cnt_q <= ret_cnt_q + LEN_WIDTH'(1);
            if (drop_cnt_q != '0) drop_cnt_q <= drop_cnt_q - DROP_W'(1);
        end
    end

    save_data_fifo #(
        .WIDTH (BUFFER_DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i ({push_last, bus.save_read_data}),
        .pop_i       (pop),
        .empty_o     (fifo_empty),
        .head_o      ({head_last, head_data})
    );

    assign bus.cmd_ready            = state_q == IDLE;
    assign bus.save_read_addr_valid = issue;
    assign bus.save_read_addr       = issue ? addr_q : '0;
    assign bus.out_valid            = !fifo_empty;
    assign bus.out_data             = fifo_empty ? '0 : head_data;
    assign bus.out_last             = !fifo_empty && head_last;
    assign bus.done                 = done_q;
    assign dbg_state_o              = state_q;

`ifdef SAVE_READER_PERF_EN
    logic [31:0] perf_port_stall_q, perf_out_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_port_stall_q <= '0;
            perf_out_stall_q  <= '0;
        end else if (accept) begin
            perf_port_stall_q <= '0;
            perf_out_stall_q  <= '0;
        end else begin
            if (state_q == ISSUE && !bus.port_free && perf_port_stall_q != '1)
                perf_port_stall_q <= perf_port_stall_q + 32'd1;
            if (!fifo_empty && !bus.out_ready && perf_out_stall_q != '1)
                perf_out_stall_q <= perf_out_stall_q + 32'd1;
        end
    end

    assign bus.perf_port_stall = perf_port_stall_q;
    assign bus.perf_out_stall  = perf_out_stall_q;
`endif

endmodule

// File: tb/tb_buffer_save_reader.sv
// Directed bench for buffer_save_reader: vector table of commands plus a
// hand-written reset-mid-command sequence; fixed-latency buffer model inside.
module tb_buffer_save_reader;
    import gnn_buffer_pkg::*;

    localparam int AW = 11, DW = 512, LW = 12, LAT = 4, DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n;
    save_reader_state_t dbg_state;

    always #5 clk = ~clk;

    buffer_save_reader_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

    buffer_save_reader #(
        .BUFFER_ADDR_WIDTH (AW),
        .BUFFER_DATA_WIDTH (DW),
        .LEN_WIDTH         (LW),
        .READ_LATENCY      (LAT),
        .FIFO_DEPTH        (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    function automatic logic [DW-1:0] mk_data(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = {a, 5'(i), 16'hC35A ^ 16'(a)};
        return d;
    endfunction

    // Buffer model: fixed read latency, reset by the same rst_n.
    logic [LAT-1:0] pipe_v;
    logic [AW-1:0]  pipe_a [LAT];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v <= '0;
            for (int i = 0; i < LAT; i++) pipe_a[i] <= '0;
        end else begin
            pipe_v    <= {pipe_v[LAT-2:0], bus.save_read_addr_valid};
            pipe_a[0] <= bus.save_read_addr;
            for (int i = 1; i < LAT; i++) pipe_a[i] <= pipe_a[i-1];
        end
    end
    assign bus.save_read_data_valid = pipe_v[LAT-1];
    assign bus.save_read_data       = mk_data(pipe_a[LAT-1]);

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [AW-1:0] base;
        logic [LW-1:0] len;
        int            pf_toggle;
        int            hold;
        logic [AW-1:0] exp_end;
        int            exp_hold_issued;
    } vec_t;

    vec_t vecs[6];
    vec_t post_vec;

    task automatic run_cmd(input vec_t v, input string tag);
        int cyc, issued, beats, done_cnt, done_cyc, last_cyc, first_iss, last_iss, hold_issued;
        logic [AW-1:0] last_addr;
        logic [AW-1:0] exp_addr_q[$];
        exp_q.delete();
        for (int i = 0; i < int'(v.len); i++) begin
            exp_addr_q.push_back(AW'(int'(v.base) + i));
            exp_q.push_back(mk_data(AW'(int'(v.base) + i)));
        end
        issued = 0; beats = 0; done_cnt = 0; done_cyc = -1;
        last_cyc = (v.len == '0) ? 0 : -100;
        first_iss = -1; last_iss = -1; hold_issued = -1; last_addr = '0;

        @(negedge clk);
        bus.cmd_valid     = 1'b1;
        bus.cmd_base_addr = v.base;
        bus.cmd_len       = v.len;
        bus.port_free     = v.pf_toggle == 0;
        bus.out_ready     = v.hold == 0;
        #1 check({tag, ".cmd_ready_start"}, 64'(bus.cmd_ready), 64'd1);

        cyc = 0;
        while (cyc < 400 && !(done_cnt > 0 && cyc >= done_cyc + 2)) begin
            cyc++;
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            bus.port_free = (v.pf_toggle == 0) ? 1'b1 : 1'(cyc % 2);
            bus.out_ready = cyc >= v.hold;
            if (cyc == v.hold) hold_issued = issued;
            #1;
            if (bus.save_read_addr_valid) begin
                check({tag, ".issue_port_free"}, 64'(bus.port_free), 64'd1);
                check({tag, ".issue_expected"}, 64'(exp_addr_q.size() > 0), 64'd1);
                if (exp_addr_q.size() > 0)
                    check({tag, ".addr"}, 64'(bus.save_read_addr), 64'(exp_addr_q.pop_front()));
                if (first_iss < 0) first_iss = cyc;
                last_iss  = cyc;
                last_addr = bus.save_read_addr;
                issued++;
            end
            if (bus.out_valid && !bus.out_ready && exp_q.size() > 0)
                check_data({tag, ".head_hold"}, bus.out_data, exp_q[0]);
            if (bus.out_valid && bus.out_ready) begin
                beats++;
                check({tag, ".beat_expected"}, 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) check_data({tag, ".data"}, bus.out_data, exp_q.pop_front());
                check({tag, ".last"}, 64'(bus.out_last), 64'(beats == int'(v.len)));
                if (bus.out_last) last_cyc = cyc;
            end
            if (bus.done) begin
                done_cnt++;
                check({tag, ".done_timing"}, 64'(cyc), 64'(last_cyc + 1));
                check({tag, ".cmd_ready_at_done"}, 64'(bus.cmd_ready), 64'd1);
                if (done_cyc < 0) done_cyc = cyc;
            end
        end

        check({tag, ".issued"}, 64'(issued), 64'(v.len));
        check({tag, ".beats"}, 64'(beats), 64'(v.len));
        check({tag, ".done_count"}, 64'(done_cnt), 64'd1);
        check({tag, ".exp_empty"}, 64'(exp_q.size()), 64'd0);
        if (v.len != '0) check({tag, ".end_addr"}, 64'(last_addr), 64'(v.exp_end));
        if (v.hold > 0) check({tag, ".hold_issued"}, 64'(hold_issued), 64'(v.exp_hold_issued));
        if (v.pf_toggle == 0 && v.hold == 0 && v.len != '0)
            check({tag, ".consecutive"}, 64'(last_iss - first_iss), 64'(int'(v.len) - 1));
        check({tag, ".cmd_ready_end"}, 64'(bus.cmd_ready), 64'd1);
        check({tag, ".state_end"}, 64'(dbg_state), 64'(IDLE));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
        check({tag, ".addr_valid"}, 64'(bus.save_read_addr_valid), 64'd0);
        check({tag, ".addr"}, 64'(bus.save_read_addr), 64'd0);
        check({tag, ".out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, ".out_last"}, 64'(bus.out_last), 64'd0);
        check({tag, ".out_data"}, 64'(bus.out_data[63:0]), 64'd0);
        check({tag, ".done"}, 64'(bus.done), 64'd0);
        check({tag, ".state"}, 64'(dbg_state), 64'(IDLE));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n             = 1'b0;
        bus.cmd_valid     = 1'b0;
        bus.cmd_base_addr = '0;
        bus.cmd_len       = '0;
        bus.port_free     = 1'b1;
        bus.out_ready     = 1'b1;
        #3;
        check_reset_values("reset");
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        vecs[0] = '{11'h010, 12'd4,  0, 0,  11'h013, 0};
        vecs[1] = '{11'h7FE, 12'd4,  0, 0,  11'h001, 0};
        vecs[2] = '{11'h100, 12'd20, 0, 30, 11'h113, 8};
        vecs[3] = '{11'h200, 12'd6,  1, 0,  11'h205, 0};
        vecs[4] = '{11'h055, 12'd0,  0, 0,  11'h000, 0};
        vecs[5] = '{11'h7F8, 12'd16, 1, 12, 11'h007, 6};
        for (int k = 0; k < 6; k++) run_cmd(vecs[k], $sformatf("vec%0d", k));

        // Reset while a 16-line command is mid-issue with beats queued.
        @(negedge clk);
        bus.cmd_valid     = 1'b1;
        bus.cmd_base_addr = 11'h300;
        bus.cmd_len       = 12'd16;
        bus.port_free     = 1'b1;
        bus.out_ready     = 1'b0;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check("mid.state_issue", 64'(dbg_state), 64'(ISSUE));
        check("mid.out_valid", 64'(bus.out_valid), 64'd1);
        #1 rst_n = 1'b0;
        #1 check_reset_values("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        post_vec = '{11'h020, 12'd2, 0, 0, 11'h021, 0};
        run_cmd(post_vec, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/buffer_save_reader.md
Name: buffer_save_reader

Overview:
- Save-path read engine sitting directly upstream of the on-chip feature buffer's save read port.
- Accepts a command (base line address, line count) and issues one address per cycle on the save port, but only when no higher-priority reader (agg, mm) holds the port.
- Absorbs the buffer's fixed read latency with credit-based flow control and a small FIFO.
- Presents the lines as a valid/ready stream, with a last flag, to the downstream DDR write (save) DMA.

Parameters:
- BUFFER_ADDR_WIDTH, 11, buffer line address width.
- BUFFER_DATA_WIDTH, 512, buffer line width in bits.
- LEN_WIDTH, 12, command length width; must be >= BUFFER_ADDR_WIDTH+1 so a full buffer can be read.
- READ_LATENCY, 4, cycles from save_read_addr_valid to save_read_data_valid.
- FIFO_DEPTH, 8, output FIFO entries; power of two, >= READ_LATENCY+2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine idle, command accepted when cmd_valid&cmd_ready
- cmd_base_addr  in  BUFFER_ADDR_WIDTH  first line address
- cmd_len  in  LEN_WIDTH  number of lines to read
- port_free  in  1  no agg/mm read request this cycle (top ties to ~agg_read_addr_valid & ~mm_read_addr_valid)
- save_read_addr_valid  out  1  read request to buffer
- save_read_addr  out  BUFFER_ADDR_WIDTH  read address
- save_read_data_valid  in  1  returned line valid
- save_read_data  in  BUFFER_DATA_WIDTH  returned line
- out_valid  out  1  stream beat valid
- out_ready  in  1  downstream accepts
- out_data  out  BUFFER_DATA_WIDTH  stream data
- out_last  out  1  final beat of command
- done  out  1  one-cycle pulse when last beat is accepted

Behaviour:
- Reset values: all outputs 0, except cmd_ready = 1. FSM in IDLE; counters and FIFO cleared.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE: cmd_ready = 1.
  - On accept with cmd_len > 0: latch base and length, go to ISSUE.
  - On accept with cmd_len == 0: pulse done the next cycle, stay in IDLE; no reads, no beats.
- ISSUE: save_read_addr_valid = port_free & (credits_used < FIFO_DEPTH).
  - credits_used = outstanding reads + FIFO occupancy.
  - On issue: address increments and wraps modulo 2^BUFFER_ADDR_WIDTH; issue counter increments.
  - After the final address is issued, go to DRAIN.
  - save_read_addr_valid is driven combinationally; save_read_addr is held at 0 when not valid.
- DRAIN: on the cycle the final beat is accepted (out_valid & out_ready & out_last), assert done and go to IDLE.
  - cmd_ready returns to 1 the following cycle.
- Credits: increment on issue, decrement on FIFO pop; simultaneous issue and pop leaves the count unchanged. The FIFO can never overflow.
- Returned data is pushed into the FIFO unconditionally on save_read_data_valid. A push while full is a design error; guard it with an assertion.
- The FIFO is first-word-fall-through: out_valid = !empty. out_data and out_last are stable while out_valid & !out_ready.
- out_last: set on the beat whose return index == len-1, tracked by a return counter.
- Simultaneous push and pop on a full FIFO is legal; the same applies on an empty FIFO once the push lands.
- port_free low stalls issue only; returns and the output stream keep flowing.
- Throughput: 1 line/cycle when port_free = 1 and out_ready = 1.
- Reset mid-operation: everything is cleared immediately. Any save_read_data_valid arriving within READ_LATENCY cycles after reset release is dropped. The buffer is reset by the same rst_n, so none is expected.

Optional Feature:
- Macro SAVE_READER_PERF_EN.
- When defined, adds outputs perf_port_stall (32 bit) and perf_out_stall (32 bit):
  - perf_port_stall counts ISSUE cycles blocked by port_free = 0.
  - perf_out_stall counts cycles with out_valid & !out_ready.
  - Both saturate at all-ones and clear on accept of a new command.
- When undefined, these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package gnn_buffer_pkg holds:
  - BUFFER_ADDR_WIDTH / BUFFER_DATA_WIDTH defaults;
  - the save_reader_state_t enum (IDLE, ISSUE, DRAIN);
  - the BUFFER_READ_LATENCY constant (4).
- Sub-module save_data_fifo: synchronous first-word-fall-through FIFO, parameterised by width and depth, with async active-low reset.

Test Plan:
- cmd base=0x010, len=4, port_free=1, out_ready=1 -> addrs 0x010..0x013 on 4 consecutive cycles; 4 beats in order, out_last on 4th; done one cycle after the last beat is accepted.
- base=0x7FE, len=4 -> addrs 0x7FE, 0x7FF, 0x000, 0x001 (wrap); data order preserved.
- len=20, out_ready=0 -> exactly FIFO_DEPTH=8 reads issued then issue halts. Raise out_ready -> remaining 12 issued, 20 beats total, no loss or duplication.
- len=6, port_free toggling 1,0,1,0... -> reads issue only on port_free=1 cycles; all 6 beats delivered in order.
- cmd_len=0 -> no save_read_addr_valid, no out_valid, done pulses once, cmd_ready stays 1.
- rst_n asserted mid-ISSUE of len=16 -> all outputs return to reset values asynchronously. A new len=2 command afterwards completes normally with exactly 2 beats.
